// File: rtl/link_frame_rsp.sv
// link_frame_rsp: answers frames addressed to LOCAL_ADDR by building a reply in the TX buffer and tracking its transmission.
// Optional macro LINK_RSP_BCAST_EN: also accept frames sent to the broadcast address 8'hFF.
module link_frame_rsp #(
  parameter logic [7:0]  LOCAL_ADDR  = 8'h01,
  parameter logic [7:0]  MAX_PAYLOAD = 8'd240,
  parameter logic [19:0] TX_TIMEOUT  = 20'd100000
) (
  input  logic        sys_clk,
  input  logic        rst,
  input  logic        rx_done,
  input  logic [1:0]  rx_crc_rslt,
  output logic        rx_buf_rden,
  output logic [10:0] rx_buf_raddr,
  input  logic [7:0]  rx_buf_rdata,
  output logic        tx_buf_wren,
  output logic [10:0] tx_buf_waddr,
  output logic [7:0]  tx_buf_wdata,
  output logic [10:0] tx_data_len,
  output logic        tx_start,
  input  logic        tx_busy,
  output logic        rsp_busy,
  output logic [15:0] rsp_cnt,
  output logic [15:0] drop_cnt,
  output logic        err_timeout
);
  typedef enum logic [2:0] {IDLE, HDR_RD, CHK, WR_HDR, COPY, START, WAIT_TX} state_t;
  state_t state_q, state_d;
  logic [7:0] cnt_q, cnt_d, dest_q, dest_d, src_q, src_d, cmd_q, cmd_d, len_q, len_d;
  logic [19:0] tmr_q, tmr_d;
  logic [10:0] tx_len_q, tx_len_d;
  logic [15:0] rsp_cnt_q, rsp_cnt_d, drop_cnt_q, drop_cnt_d;
  logic seen_q, seen_d, dest_ok, accept, done, timeout, drop_rx, drop_int;
`ifdef LINK_RSP_BCAST_EN
  assign dest_ok = (dest_q == LOCAL_ADDR) || (dest_q == 8'hFF);
`else
  assign dest_ok = dest_q == LOCAL_ADDR;
`endif
  assign accept   = dest_ok && (len_q <= MAX_PAYLOAD);
  assign done     = (state_q == WAIT_TX) && seen_q && !tx_busy;
  assign timeout  = (state_q == WAIT_TX) && !done && (tmr_q == TX_TIMEOUT - 20'd1);
  // A new frame is lost if it fails CRC or arrives while a reply is still in progress
  assign drop_rx  = rx_done && ((state_q != IDLE) || (rx_crc_rslt != 2'b01));
  assign drop_int = ((state_q == CHK) && !accept) || timeout;
  always_ff @(posedge sys_clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      dest_q     <= '0;
      src_q      <= '0;
      cmd_q      <= '0;
      len_q      <= '0;
      tmr_q      <= '0;
      tx_len_q   <= '0;
      rsp_cnt_q  <= '0;
      drop_cnt_q <= '0;
      seen_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dest_q     <= dest_d;
      src_q      <= src_d;
      cmd_q      <= cmd_d;
      len_q      <= len_d;
      tmr_q      <= tmr_d;
      tx_len_q   <= tx_len_d;
      rsp_cnt_q  <= rsp_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      seen_q     <= seen_d;
    end
  end
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dest_d     = dest_q;
    src_d      = src_q;
    cmd_d      = cmd_q;
    len_d      = len_q;
    tmr_d      = tmr_q;
    tx_len_d   = tx_len_q;
    seen_d     = seen_q;
    rsp_cnt_d  = rsp_cnt_q + 16'(done);
    drop_cnt_d = drop_cnt_q + 16'(drop_rx) + 16'(drop_int);
    case (state_q)
      IDLE: begin
        cnt_d   = '0;
        state_d = (rx_done && rx_crc_rslt == 2'b01) ? HDR_RD : IDLE;
      end
      HDR_RD: begin
        // rdata lags the address by one cycle, so capture index is cnt-1
        cnt_d   = cnt_q + 8'd1;
        dest_d  = (cnt_q == 8'd1) ? rx_buf_rdata : dest_q;
        src_d   = (cnt_q == 8'd2) ? rx_buf_rdata : src_q;
        cmd_d   = (cnt_q == 8'd3) ? rx_buf_rdata : cmd_q;
        len_d   = (cnt_q == 8'd4) ? rx_buf_rdata : len_q;
        state_d = (cnt_q == 8'd4) ? CHK : HDR_RD;
      end
      CHK: begin
        cnt_d    = '0;
        tx_len_d = accept ? 11'd4 + {3'b0, len_q} : tx_len_q;
        state_d  = accept ? WR_HDR : IDLE;
      end
      WR_HDR: begin
        cnt_d   = (cnt_q == 8'd3) ? 8'd0 : cnt_q + 8'd1;
        state_d = (cnt_q != 8'd3) ? WR_HDR : (len_q != 8'd0) ? COPY : START;
      end
      COPY: begin
        cnt_d   = cnt_q + 8'd1;
        state_d = (cnt_q == len_q) ? START : COPY;
      end
      START: begin
        tmr_d   = '0;
        seen_d  = 1'b0;
        state_d = WAIT_TX;
      end
      WAIT_TX: begin
        tmr_d   = tmr_q + 20'd1;
        seen_d  = seen_q || tx_busy;
        state_d = (done || timeout) ? IDLE : WAIT_TX;
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    rx_buf_rden  = ((state_q == HDR_RD) && (cnt_q < 8'd4)) || ((state_q == COPY) && (cnt_q < len_q));
    rx_buf_raddr = !rx_buf_rden ? 11'd0 : (state_q == HDR_RD) ? {3'b0, cnt_q} : 11'd4 + {3'b0, cnt_q};
    tx_buf_wren  = (state_q == WR_HDR) || ((state_q == COPY) && (cnt_q != 8'd0));
    tx_buf_waddr = !tx_buf_wren ? 11'd0 : (state_q == WR_HDR) ? {3'b0, cnt_q} : 11'd3 + {3'b0, cnt_q};
    tx_buf_wdata = !tx_buf_wren ? 8'd0 :
                   (state_q == COPY)  ? rx_buf_rdata :
                   (cnt_q == 8'd0)    ? src_q :
                   (cnt_q == 8'd1)    ? LOCAL_ADDR :
                   (cnt_q == 8'd2)    ? (cmd_q | 8'h80) : len_q;
    tx_data_len  = tx_len_q;
    tx_start     = state_q == START;
    rsp_busy     = state_q != IDLE;
    rsp_cnt      = rsp_cnt_q;
    drop_cnt     = drop_cnt_q;
    err_timeout  = timeout;
  end
endmodule

// File: tb/tb_link_frame_rsp.sv
// tb_link_frame_rsp: directed frames with a write/length scoreboard checked by a negedge monitor.
module tb_link_frame_rsp;
  logic sys_clk = 1'b0, rst = 1'b0, rx_done = 1'b0, tx_busy = 1'b0;
  logic [1:0] rx_crc_rslt = 2'b00;
  logic rx_buf_rden, tx_buf_wren, tx_start, rsp_busy, err_timeout;
  logic [10:0] rx_buf_raddr, tx_buf_waddr, tx_data_len;
  logic [7:0] rx_buf_rdata = 8'd0, tx_buf_wdata;
  logic [15:0] rsp_cnt, drop_cnt;
  typedef struct {logic [10:0] a; logic [7:0] d;} wr_t;
  wr_t wq[$];
  logic [10:0] lq[$];
  wr_t mw;
  logic [10:0] ml;
  logic [7:0] rxmem [0:2047];
  int tests = 0, fails = 0, rden_n = 0, exp_rsp = 0, exp_drop = 0;

  link_frame_rsp #(.LOCAL_ADDR(8'h01), .MAX_PAYLOAD(8'd240), .TX_TIMEOUT(20'd50)) dut (
    .sys_clk(sys_clk), .rst(rst), .rx_done(rx_done), .rx_crc_rslt(rx_crc_rslt),
    .rx_buf_rden(rx_buf_rden), .rx_buf_raddr(rx_buf_raddr), .rx_buf_rdata(rx_buf_rdata),
    .tx_buf_wren(tx_buf_wren), .tx_buf_waddr(tx_buf_waddr), .tx_buf_wdata(tx_buf_wdata),
    .tx_data_len(tx_data_len), .tx_start(tx_start), .tx_busy(tx_busy), .rsp_busy(rsp_busy),
    .rsp_cnt(rsp_cnt), .drop_cnt(drop_cnt), .err_timeout(err_timeout));

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) if (rx_buf_rden) rx_buf_rdata <= rxmem[rx_buf_raddr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every TX write and tx_start must match the next scoreboard entry
  always @(negedge sys_clk) begin
    if (rx_buf_rden) begin
      rden_n++;
      if (rx_buf_raddr > 11'd243) chk("rx read bound", {21'd0, rx_buf_raddr}, 32'd243);
    end
    if (tx_buf_wren) begin
      if (wq.size() == 0) chk("unexpected tx write addr", {21'd0, tx_buf_waddr}, 32'hFFFF);
      else begin
        mw = wq.pop_front();
        chk("tx waddr", {21'd0, tx_buf_waddr}, {21'd0, mw.a});
        chk("tx wdata", {24'd0, tx_buf_wdata}, {24'd0, mw.d});
      end
    end
    if (tx_start) begin
      if (lq.size() == 0) chk("unexpected tx_start", 32'd1, 32'd0);
      else begin
        ml = lq.pop_front();
        chk("tx_data_len", {21'd0, tx_data_len}, {21'd0, ml});
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic send(input logic [7:0] dest, src, cmd, len, pb, input logic [1:0] crc, input bit rsp);
    logic [7:0] p;
    rxmem[0] = dest; rxmem[1] = src; rxmem[2] = cmd; rxmem[3] = len;
    for (int i = 0; i < int'(len); i++) begin
      p = pb + 8'(i * 17);
      rxmem[4 + i] = p;
      if (rsp) wq.push_back('{11'(4 + i), p});
    end
    if (rsp) begin
      wq.push_front('{11'd3, len});
      wq.push_front('{11'd2, cmd | 8'h80});
      wq.push_front('{11'd1, 8'h01});
      wq.push_front('{11'd0, src});
      lq.push_back(11'd4 + {3'b0, len});
    end
    @(negedge sys_clk);
    rx_done = 1'b1; rx_crc_rslt = crc;
    @(negedge sys_clk);
    rx_done = 1'b0; rx_crc_rslt = 2'b00;
  endtask

  task automatic wait_start(input string name);
    int n = 0;
    while (!tx_start && n < 2000) begin @(negedge sys_clk); n++; end
    chk(name, {31'd0, tx_start}, 32'd1);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (rsp_busy && n < 2000) begin @(negedge sys_clk); n++; end
    chk(name, {31'd0, rsp_busy}, 32'd0);
  endtask

  // Link side: start, then a short busy burst, then wait for the responder to settle
  task automatic serve(input string name);
    wait_start({name, " tx_start"});
    cyc(2); tx_busy = 1'b1; cyc(5); tx_busy = 1'b0;
    wait_idle({name, " idle"});
    exp_rsp++;
  endtask

  task automatic counters(input string name);
    chk({name, " rsp_cnt"}, {16'd0, rsp_cnt}, exp_rsp);
    chk({name, " drop_cnt"}, {16'd0, drop_cnt}, exp_drop);
    chk({name, " sb drained"}, wq.size() + lq.size(), 32'd0);
  endtask

  task automatic wait_raddr(input logic [10:0] a, input string name);
    int n = 0;
    while (!(rx_buf_rden && rx_buf_raddr == a) && n < 200) begin @(negedge sys_clk); n++; end
    chk(name, {21'd0, rx_buf_raddr}, {21'd0, a});
  endtask

  initial begin
    int n;
    for (int i = 0; i < 2048; i++) rxmem[i] = 8'd0;
    cyc(3);
    chk("reset outputs", {rsp_busy, rx_buf_rden, tx_buf_wren, tx_start, err_timeout, tx_data_len}, 32'd0);
    chk("reset counters", {rsp_cnt, drop_cnt}, 32'd0);
    rst = 1'b1; cyc(2);
    // 1: basic reply
    send(8'h01, 8'h05, 8'h12, 8'd3, 8'hAA, 2'b01, 1'b1);
    serve("t1"); counters("t1");
    // 2: CRC failure never touches the RX buffer
    rden_n = 0;
    send(8'h01, 8'h05, 8'h12, 8'd3, 8'hAA, 2'b10, 1'b0);
    cyc(20); exp_drop++;
    chk("t2 no rden", rden_n, 32'd0); counters("t2");
    // 3: foreign and broadcast destinations
    send(8'h02, 8'h05, 8'h12, 8'd3, 8'hAA, 2'b01, 1'b0);
    wait_idle("t3 foreign idle"); exp_drop++; counters("t3a");
`ifdef LINK_RSP_BCAST_EN
    send(8'hFF, 8'h07, 8'h21, 8'd2, 8'h10, 2'b01, 1'b1);
    serve("t3 bcast");
`else
    send(8'hFF, 8'h07, 8'h21, 8'd2, 8'h10, 2'b01, 1'b0);
    wait_idle("t3 bcast idle"); exp_drop++;
`endif
    counters("t3b");
    // 4: zero and oversize payload lengths
    send(8'h01, 8'h09, 8'h33, 8'd0, 8'h00, 2'b01, 1'b1);
    serve("t4 len0"); counters("t4a");
    send(8'h01, 8'h09, 8'h33, 8'd241, 8'h00, 2'b01, 1'b0);
    wait_idle("t4 len241 idle"); exp_drop++; counters("t4b");
    // 5: link never goes busy -> timeout 50 cycles after tx_start
    send(8'h01, 8'h0A, 8'h01, 8'd2, 8'h40, 2'b01, 1'b1);
    wait_start("t5 tx_start");
    n = 0;
    do begin @(negedge sys_clk); n++; end while (!err_timeout && n < 200);
    chk("t5 timeout cycle", n, 32'd50);
    @(negedge sys_clk);
    chk("t5 pulse width", {31'd0, err_timeout}, 32'd0);
    chk("t5 back idle", {31'd0, rsp_busy}, 32'd0);
    exp_drop++; counters("t5");
    // 6a: second frame during COPY is dropped, first reply completes
    send(8'h01, 8'h0B, 8'h44, 8'd6, 8'h01, 2'b01, 1'b1);
    wait_raddr(11'd6, "t6a in copy");
    rx_done = 1'b1; rx_crc_rslt = 2'b01; @(negedge sys_clk); rx_done = 1'b0; rx_crc_rslt = 2'b00;
    serve("t6a"); exp_drop++; counters("t6a");
    // 6b: reset during COPY abandons the frame
    send(8'h01, 8'h0C, 8'h55, 8'd8, 8'h02, 2'b01, 1'b1);
    wait_raddr(11'd8, "t6b in copy");
    rst = 1'b0; @(negedge sys_clk);
    chk("t6b outputs", {rsp_busy, rx_buf_rden, tx_buf_wren, tx_start, err_timeout, tx_data_len}, 32'd0);
    chk("t6b counters", {rsp_cnt, drop_cnt}, 32'd0);
    rst = 1'b1; wq.delete(); lq.delete(); exp_rsp = 0; exp_drop = 0;
    cyc(30); counters("t6b after");
    // recovery after reset
    send(8'h01, 8'h0D, 8'h66, 8'd1, 8'h77, 2'b01, 1'b1);
    serve("t7"); counters("t7");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/link_frame_rsp.md
Name: link_frame_rsp

Overview:
- Link-layer responder on the client side of the DAL PHY link block.
- Consumes frames the link has received: on rx-done, reads the header and payload out of the RX buffer, validates it, and builds a reply frame in the TX buffer.
- Then pulses tx_start and tracks the transmission to completion.
- Closes the loop between the link's receive and transmit paths: it is the responding end that answers frames from the initiating station.

Parameters:
LOCAL_ADDR, 8'h01, station address this block answers to
MAX_PAYLOAD, 8'd240, largest accepted payload length in bytes; larger len field causes drop
TX_TIMEOUT, 20'd100000, sys_clk cycles allowed from tx_start until tx_busy deasserts

Ports:
sys_clk  in  1  system clock, all logic rising-edge
rst  in  1  reset, synchronous, active-low
rx_done  in  1  one-cycle pulse: frame complete in RX buffer
rx_crc_rslt  in  2  sampled with rx_done; 2'b01 = CRC pass, any other value = fail
rx_buf_rden  out  1  RX buffer read enable
rx_buf_raddr  out  11  RX buffer byte address
rx_buf_rdata  in  8  RX buffer data, valid 1 cycle after rden/raddr
tx_buf_wren  out  1  TX buffer write enable
tx_buf_waddr  out  11  TX buffer byte address
tx_buf_wdata  out  8  TX buffer write data
tx_data_len  out  11  reply length in bytes, stable from tx_start until DONE
tx_start  out  1  one-cycle pulse to start link transmission
tx_busy  in  1  high while the link transmits (link tx enable)
rsp_busy  out  1  high in any state other than IDLE
rsp_cnt  out  16  replies sent, wraps at 16'hFFFF->0
drop_cnt  out  16  frames dropped, wraps
err_timeout  out  1  one-cycle pulse on TX timeout

Behaviour:
- Reset (rst=0 at clock edge): state IDLE; all outputs 0; counters 0; internal regs 0. Reset mid-frame abandons the frame immediately; no tx_start is issued afterwards.
- Frame format (bytes at addr 0..): [0]=dest, [1]=src, [2]=cmd, [3]=len, [4..3+len]=payload.
- IDLE: on rx_done: if crc==2'b01 -> HDR_RD; otherwise drop_cnt++ and stay in IDLE.
- HDR_RD: rden=1, raddr 0..3 on 4 consecutive cycles. Data is captured 1 cycle later into dest/src/cmd/len regs; the last capture occurs on the 5th cycle -> CHK.
- CHK (1 cycle): accept iff dest==LOCAL_ADDR and len<=MAX_PAYLOAD. Accept -> WR_HDR; reject -> drop_cnt++, IDLE.
- WR_HDR: 4 writes at waddr 0..3, data = {src, LOCAL_ADDR, cmd|8'h80, len}. Then COPY if len!=0, else START.
- COPY: raddr runs 4..3+len, rden high throughout. wren is delayed 1 cycle, waddr=raddr-1-cycle copy, wdata=rx_buf_rdata. Exactly len writes, then START.
- START: tx_data_len = 4+len (zero-extended), tx_start=1 for one cycle -> WAIT_TX; the timeout counter is cleared.
- WAIT_TX: first wait for tx_busy=1, then for tx_busy=0. On that falling edge: rsp_cnt++, -> IDLE.
- WAIT_TX timeout: if TX_TIMEOUT cycles elapse without the falling edge, err_timeout pulses, drop_cnt++, -> IDLE.
- rx_done arriving while not IDLE: the frame is ignored and drop_cnt++. The frame in progress is unaffected.
- rx_buf_rden, tx_buf_wren and tx_start are 0 in all states other than those listed above.
- No reads of the RX buffer beyond address 3+MAX_PAYLOAD.

Optional Feature:
LINK_RSP_BCAST_EN
- Defined: dest==8'hFF also passes CHK. Reply byte1 remains LOCAL_ADDR.
- Not defined: 8'hFF is treated like any foreign address (drop).

Test Plan:
1. Reset, then rx_done with crc 2'b01, frame {01,05,12,03,AA,BB,CC} -> TX buffer gets {05,01,92,03,AA,BB,CC}; tx_data_len=7; one tx_start; after a tx_busy pulse, rsp_cnt=1.
2. Same frame with crc 2'b10 -> no rden, no tx_start; drop_cnt=1.
3. dest=02 -> drop_cnt=1, no tx writes. dest=FF -> reply only when LINK_RSP_BCAST_EN is defined.
4. len=0 -> 4 header writes only, tx_data_len=4. len=241 -> drop.
5. tx_busy held 0 after tx_start with TX_TIMEOUT=50 -> err_timeout pulses at cycle 50; drop_cnt++; back to IDLE.
6. Second rx_done during COPY -> first reply completes intact, drop_cnt=1. rst=0 during COPY -> all outputs 0 next cycle, no tx_start.
